sram_fb_writer: RTL and testbench



---
 rtl/sram_fb_writer.sv | 158 +++++++++++++++
 tb/tb_sram_fb_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_fb_writer.sv
// sram_fb_writer: framebuffer write port for the SXGA video path.
// Host pixel writes are queued in a small FIFO and drained as 3-clock
// asynchronous SRAM write cycles (SETUP / STROBE / HOLD) only when the
// scan-out stage is not fetching and cannot start fetching mid-cycle.
// Optional feature macro: FBW_BYTE_EN_EN adds per-word byte enables (wr_be).
module sram_fb_writer #(
  parameter int DEPTH       = 16,
  parameter int FETCH_START = 407,
  parameter int HCNT_W      = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [17:0]              wr_addr,
  input  logic [15:0]              wr_data,
`ifdef FBW_BYTE_EN_EN
  input  logic [1:0]               wr_be,
`endif
  input  logic [HCNT_W-1:0]        hcnt,
  input  logic                     hfetch,
  input  logic                     vvis,
  output logic                     own,
  output logic [17:0]              sram_addr,
  output logic [15:0]              sram_dout,
  output logic                     sram_dout_en,
  output logic                     sram_we_n,
  output logic                     sram_lb_n,
  output logic                     sram_ub_n,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
`ifdef FBW_BYTE_EN_EN
  localparam int EW = 36;
`else
  localparam int EW = 34;
`endif
  // Last hcnt at which a 3-clock write can start and still release the bus
  // before scan-out begins fetching.
  localparam logic [HCNT_W-1:0] GUARD = HCNT_W'(FETCH_START - 4);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_go;
  logic [EW-1:0] w_din;
  logic [EW-1:0] w_rd;
  logic [17:0]   r_addr;
  logic [15:0]   r_data;
`ifdef FBW_BYTE_EN_EN
  logic [1:0]    r_be;
  assign w_din = {wr_be, wr_addr, wr_data};
`else
  assign w_din = {wr_addr, wr_data};
`endif

  // Full is judged from the registered count only, so a full FIFO never
  // accepts a word even on a cycle where it is also popped.
  assign wr_ready   = (r_count != (AW+1)'(DEPTH));
  assign w_push     = wr_valid && wr_ready;
  assign fifo_level = r_count;
  assign w_rd       = r_mem[r_rptr];

  assign w_go = !hfetch && (!vvis || (hcnt <= GUARD)) && (r_count != '0);

  // FIFO storage; contents need no reset because the count gates reads.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_din;
  end

  // FIFO pointers and occupancy count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-cycle state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and pop: a new word is taken only from IDLE or HOLD.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_go) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Address/data/byte-enable registers load only on the edge entering
  // SETUP, so they stay stable one clock either side of the WE pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= '0;
      r_data <= '0;
`ifdef FBW_BYTE_EN_EN
      r_be   <= '0;
`endif
    end else if (w_pop) begin
      r_addr <= w_rd[33:16];
      r_data <= w_rd[15:0];
`ifdef FBW_BYTE_EN_EN
      r_be   <= w_rd[35:34];
`endif
    end
  end

  assign own          = (r_state != S_IDLE);
  assign sram_dout_en = own;
  assign sram_we_n    = (r_state != S_STROBE);
  assign sram_addr    = r_addr;
  assign sram_dout    = r_data;
`ifdef FBW_BYTE_EN_EN
  assign sram_lb_n    = own ? ~r_be[0] : 1'b0;
  assign sram_ub_n    = own ? ~r_be[1] : 1'b0;
`else
  assign sram_lb_n    = 1'b0;
  assign sram_ub_n    = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fb_writer.sv
// Directed bench for sram_fb_writer: single write, guard boundary, fetch
// blocking, full FIFO back-pressure, reset mid-write, blanking drain and
// (when FBW_BYTE_EN_EN is defined) byte enables.
module tb_sram_fb_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [17:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
`ifdef FBW_BYTE_EN_EN
  logic [1:0]  wr_be = 2'b11;
`endif
  logic [10:0] hcnt = '0;
  logic        hfetch = 1'b0;
  logic        vvis = 1'b1;
  logic        own;
  logic [17:0] sram_addr;
  logic [15:0] sram_dout;
  logic        sram_dout_en;
  logic        sram_we_n;
  logic        sram_lb_n;
  logic        sram_ub_n;
  logic [4:0]  fifo_level;

  int          n_vec = 0;
  int          n_err = 0;
  bit          run_h = 1'b0;
  bit          auto_f = 1'b0;
  logic [33:0] exp_q[$];

  sram_fb_writer #(.DEPTH(16), .FETCH_START(407), .HCNT_W(11)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef FBW_BYTE_EN_EN
    .wr_be(wr_be),
`endif
    .hcnt(hcnt), .hfetch(hfetch), .vvis(vvis), .own(own),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_dout_en(sram_dout_en),
    .sram_we_n(sram_we_n), .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; inputs and samples happen 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (run_h) hcnt = (hcnt == 11'd1687) ? 11'd0 : hcnt + 11'd1;
    if (auto_f) hfetch = (hcnt >= 11'd407) && (hcnt < 11'd1687);
  endtask

  task automatic push_word(input logic [17:0] a, input logic [15:0] d);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    chk("push_ready", wr_ready, 1);
    if (wr_ready) exp_q.push_back({a, d});
    step();
    wr_valid = 1'b0;
  endtask

  // Follow queued writes; run0 is how many clocks of the current cycle
  // were already observed by the caller.
  task automatic drain(input string tag, input int run0, output int span);
    int run;
    logic [33:0] e;
    run  = run0;
    span = run0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (own) begin
        span++;
        if (run % 3 == 0) begin
          if (exp_q.size() == 0) begin
            chk({tag, "_extra_wr"}, 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk({tag, "_addr"}, 32'(sram_addr), 32'(e[33:16]));
            chk({tag, "_data"}, 32'(sram_dout), 32'(e[15:0]));
          end
        end
        chk({tag, "_we_n"}, 32'(sram_we_n), (run % 3 == 1) ? 32'd0 : 32'd1);
        chk({tag, "_be_n"}, {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
        run++;
      end else begin
        run = 0;
        if (exp_q.size() == 0) break;
      end
    end
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int span;
    int bad;
    bit started;

    // Reset state
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_own", own, 0);
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_dout_en", sram_dout_en, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", wr_ready, 1);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dout", sram_dout, 0);
    chk("rst_be_n", {sram_ub_n, sram_lb_n}, 0);

    // Single write inside the visible window, early in the line
    vvis = 1'b1; hfetch = 1'b0; hcnt = 11'd100;
    push_word(18'h00123, 16'hA5C3);
    chk("single_own_push", own, 0);
    chk("single_level_push", fifo_level, 1);
    step();
    chk("single_setup_own", own, 1);
    chk("single_setup_we", sram_we_n, 1);
    chk("single_setup_en", sram_dout_en, 1);
    chk("single_setup_addr", sram_addr, 32'h00123);
    chk("single_setup_data", sram_dout, 32'hA5C3);
    chk("single_level_pop", fifo_level, 0);
    step();
    chk("single_strobe_own", own, 1);
    chk("single_strobe_we", sram_we_n, 0);
    chk("single_strobe_addr", sram_addr, 32'h00123);
    step();
    chk("single_hold_own", own, 1);
    chk("single_hold_we", sram_we_n, 1);
    chk("single_hold_data", sram_dout, 32'hA5C3);
    step();
    chk("single_end_own", own, 0);
    chk("single_end_en", sram_dout_en, 0);
    exp_q.delete();

    // Guard: go seen at hcnt=403 writes during 404..406 and frees the bus at 407
    run_h = 1'b1; auto_f = 1'b1; hcnt = 11'd402;
    push_word(18'h01111, 16'h1111);
    chk("g403_hcnt", hcnt, 403);
    chk("g403_own_idle", own, 0);
    step(); chk("g403_own_404", own, 1);
    step(); chk("g403_we_405", sram_we_n, 0);
    step(); chk("g403_own_406", own, 1);
    step(); chk("g403_own_407", own, 0);
    chk("g403_hfetch_407", hfetch, 1);
    exp_q.delete();

    // Guard: go seen at hcnt=404 is blocked until the next line's start
    hcnt = 11'd403; hfetch = 1'b0;
    push_word(18'h02222, 16'h2222);
    chk("g404_hcnt", hcnt, 404);
    bad = 0; started = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (own) begin started = 1'b1; break; end
      step();
      if (own && hfetch) bad++;
    end
    chk("g404_started", started, 1);
    chk("g404_overlap", bad, 0);
    chk("g404_start_hcnt", hcnt, 1);
    chk("g404_addr", sram_addr, 32'h02222);
    step(); step(); step();
    chk("g404_end_own", own, 0);
    exp_q.delete();
    run_h = 1'b0; auto_f = 1'b0; hfetch = 1'b0; hcnt = 11'd100;

    // Fetch block: five queued words wait out a long fetch window
    hfetch = 1'b1;
    for (int i = 0; i < 5; i++) push_word(18'(18'h10000 + i), 16'(16'hC000 + i * 3));
    chk("fetch_level", fifo_level, 5);
    bad = 0;
    for (int c = 0; c < 1280; c++) begin
      step();
      if (own) bad++;
    end
    chk("fetch_own", bad, 0);
    hfetch = 1'b0;
    drain("fetch_drain", 0, span);
    chk("fetch_span", span, 15);

    // Full FIFO: 16 accepted, 17th held by the host and written later
    hfetch = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wr_addr = 18'(18'h20000 + i);
      wr_data = 16'(16'hF000 + i);
      wr_valid = 1'b1;
      if (i < 16) begin
        chk("full_ready_fill", wr_ready, 1);
        exp_q.push_back({wr_addr, wr_data});
      end else begin
        chk("full_ready_17", wr_ready, 0);
      end
      step();
    end
    chk("full_level", fifo_level, 16);
    chk("full_ready", wr_ready, 0);
    hfetch = 1'b0;
    chk("full_ready_pop_cycle", wr_ready, 0);
    step();
    chk("full_first_own", own, 1);
    chk("full_first_addr", sram_addr, 32'h20000);
    void'(exp_q.pop_front());
    chk("full_ready_after_pop", wr_ready, 1);
    exp_q.push_back({wr_addr, wr_data});
    step();
    wr_valid = 1'b0;
    chk("full_strobe_we", sram_we_n, 0);
    drain("full_drain", 2, span);
    chk("full_span", span, 51);

    // Reset asserted during STROBE flushes everything
    hfetch = 1'b1;
    for (int i = 0; i < 3; i++) push_word(18'(18'h30000 + i), 16'(16'h3000 + i));
    hfetch = 1'b0;
    step();
    step();
    chk("rmw_strobe_we", sram_we_n, 0);
    rst = 1'b1;
    step();
    chk("rmw_we_n", sram_we_n, 1);
    chk("rmw_own", own, 0);
    chk("rmw_level", fifo_level, 0);
    chk("rmw_ready", wr_ready, 1);
    chk("rmw_addr", sram_addr, 0);
    rst = 1'b0;
    exp_q.delete();
    step(); step();
    chk("rmw_after_own", own, 0);

    // Vertical blank: late hcnt is allowed, back-to-back at 3 clocks/word
    hfetch = 1'b1; vvis = 1'b0; hcnt = 11'd500;
    for (int i = 0; i < 3; i++) push_word(18'(18'h3FF00 + i), 16'(16'h5A00 + i));
    hfetch = 1'b0;
    drain("vblank_drain", 0, span);
    chk("vblank_span", span, 9);
    vvis = 1'b1; hcnt = 11'd100;

`ifdef FBW_BYTE_EN_EN
    // Byte enables: low byte only
    wr_be = 2'b01;
    push_word(18'h00456, 16'h00EE);
    wr_be = 2'b11;
    chk("be_idle_lb", sram_lb_n, 0);
    chk("be_idle_ub", sram_ub_n, 0);
    step();
    chk("be_setup_lb", sram_lb_n, 0);
    chk("be_setup_ub", sram_ub_n, 1);
    step();
    chk("be_strobe_ub", sram_ub_n, 1);
    step(); step();
    chk("be_end_ub", sram_ub_n, 0);
    exp_q.delete();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
